// File: rtl/bcd_countdown_timer_if.sv
// Signal bundle between the game logic and the BCD countdown timer.
//   start        run enable (high = advance, low = pause)
//   load         single-cycle request to load load_bcd
//   load_bcd     packed BCD reload value, digit 0 in bits [3:0]
//   count_up     0 = count down toward 0, 1 = count up toward all-9s
//   count_bcd    current value, packed BCD, registered
//   tick         one-cycle pulse on every count step attempt
//   expired      level, high while count_bcd is the terminal value
//   expire_pulse one-cycle pulse on the step that reaches the terminal value
// master = the controlling side (game logic), slave = the timer itself.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic                  count_up;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  tick;
  logic                  expired;
  logic                  expire_pulse;

  modport master (
    output start, load, load_bcd, count_up,
    input  count_bcd, tick, expired, expire_pulse
  );

  modport slave (
    input  start, load, load_bcd, count_up,
    output count_bcd, tick, expired, expire_pulse
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD second timer. A prescaler divides clock down to one step
// every TICK_CYCLES enabled cycles; each step decrements (or increments) a
// DIGITS-wide packed BCD counter that saturates at all-0 (down) or all-9 (up).
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-high reset
//   tmr    slave side of bcd_countdown_timer_if (controls in, count/flags out)
module bcd_countdown_timer #(
  parameter int                    TICK_CYCLES = 50_000_000,
  parameter int                    DIGITS      = 2,
  parameter logic [4*DIGITS-1:0]   INIT_BCD    = 8'h20
) (
  input  logic                     clock,
  input  logic                     reset,
  bcd_countdown_timer_if.slave     tmr
);

  localparam int                  W         = 4 * DIGITS;
  localparam int                  PW        = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [W-1:0]        NINES     = {DIGITS{4'h9}};

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic          tick_q, tick_d;
  logic          expire_pulse_q, expire_pulse_d;

  logic [W-1:0]  dec_bcd;
  logic [W-1:0]  inc_bcd;
  logic [W-1:0]  load_clean;
  logic [W-1:0]  step_bcd;
  logic [W-1:0]  term_bcd;
  logic          at_term;
  logic          wrap;

  // Per-digit BCD arithmetic. A digit receives a borrow (carry) exactly when
  // every lower digit is 0 (9), so each digit is computed directly from the
  // lower bits instead of through a ripple chain.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      logic [3:0] ld_dig;
      logic       borrow_in;
      logic       carry_in;

      assign dig    = count_q[4*gi +: 4];
      assign ld_dig = tmr.load_bcd[4*gi +: 4];

      if (gi == 0) begin : g_lsd
        assign borrow_in = 1'b1;
        assign carry_in  = 1'b1;
      end else begin : g_upper
        assign borrow_in = (count_q[4*gi-1:0] == '0);
        assign carry_in  = (count_q[4*gi-1:0] == NINES[4*gi-1:0]);
      end

      assign dec_bcd[4*gi +: 4] = !borrow_in ? dig :
                                  (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      assign inc_bcd[4*gi +: 4] = !carry_in ? dig :
                                  (dig >= 4'd9) ? 4'd0 : dig + 4'd1;

      // Non-decimal nibbles on the reload bus are clamped to 9.
      assign load_clean[4*gi +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
    end
  endgenerate

  // Terminal value follows the live direction so expired re-evaluates as
  // soon as count_up changes, not at the next step.
  assign term_bcd = tmr.count_up ? NINES : '0;
  assign step_bcd = tmr.count_up ? inc_bcd : dec_bcd;
  assign at_term  = (count_q == term_bcd);
  assign wrap     = tmr.start && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d        = presc_q;
    count_d        = count_q;
    tick_d         = 1'b0;
    expire_pulse_d = 1'b0;

    if (tmr.load) begin
      // Load beats a coincident step; the partial second is discarded.
      count_d = load_clean;
      presc_d = '0;
    end else if (tmr.start) begin
      if (wrap) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // Saturated: tick still fires but the value and pulse stay quiet.
        if (!at_term) begin
          count_d        = step_bcd;
          expire_pulse_d = (step_bcd == term_bcd);
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q        <= '0;
      count_q        <= INIT_BCD;
      tick_q         <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      count_q        <= count_d;
      tick_q         <= tick_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign tmr.count_bcd    = count_q;
  assign tmr.tick         = tick_q;
  assign tmr.expire_pulse = expire_pulse_q;
  assign tmr.expired      = at_term;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: the stimulus process predicts every cycle's outputs with
// an integer-valued model and queues them; a monitor pops one entry per
// clock and compares it against the DUT.
module tb_bcd_countdown_timer;

  localparam int TICK   = 4;
  localparam int DIGITS = 2;
  localparam int MAXV   = 99;
  localparam int INITV  = 20;

  logic clock;
  logic reset;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(
    .TICK_CYCLES (TICK),
    .DIGITS      (DIGITS),
    .INIT_BCD    (8'h20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tmr   (bus)
  );

  typedef struct {
    int   cyc;
    int   val;
    logic tick;
    logic ep;
  } exp_t;

  exp_t sb_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc_cnt       = 0;

  // Reference model state: plain integers.
  int m_val   = 0;
  int m_presc = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int sanit(input logic [7:0] v);
    int acc;
    int p;
    int n;
    acc = 0;
    p   = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'((v >> (4 * i)) & 8'h0F);
      if (n > 9) n = 9;
      acc += n * p;
      p   *= 10;
    end
    return acc;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  // Apply one cycle of inputs, predict the state after the coming edge,
  // queue it, and move just past that edge.
  task automatic drive(input logic r, input logic s, input logic l,
                       input logic [7:0] lb, input logic u);
    exp_t e;
    int   term;
    reset        = r;
    bus.start    = s;
    bus.load     = l;
    bus.load_bcd = lb;
    bus.count_up = u;
    e.tick = 1'b0;
    e.ep   = 1'b0;
    if (r) begin
      m_val   = INITV;
      m_presc = 0;
    end else if (l) begin
      m_val   = sanit(lb);
      m_presc = 0;
    end else if (s) begin
      if (m_presc == TICK - 1) begin
        m_presc = 0;
        e.tick  = 1'b1;
        term    = u ? MAXV : 0;
        if (m_val != term) begin
          m_val = u ? m_val + 1 : m_val - 1;
          e.ep  = (m_val == term);
        end
      end else begin
        m_presc++;
      end
    end
    cyc_cnt++;
    e.cyc = cyc_cnt;
    e.val = m_val;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input logic s, input logic u);
    for (int i = 0; i < n; i++) drive(1'b0, s, 1'b0, 8'h00, u);
  endtask

  task automatic load_val(input logic [7:0] lb, input logic s, input logic u);
    drive(1'b0, s, 1'b1, lb, u);
  endtask

  // Monitor: one expected entry per clock, sampled well after the edge.
  initial begin
    exp_t       e;
    logic [7:0] exp_bcd;
    logic       exp_expired;
    forever begin
      @(posedge clock);
      #3;
      if (sb_q.size() > 0) begin
        e           = sb_q.pop_front();
        exp_bcd     = to_bcd(e.val);
        // expired is combinational on count_up, which is already the value
        // driven for the following cycle.
        exp_expired = (e.val == (bus.count_up ? MAXV : 0));
        checks_total++;
        if (bus.count_bcd === exp_bcd && bus.tick === e.tick &&
            bus.expire_pulse === e.ep && bus.expired === exp_expired) begin
          checks_passed++;
        end else begin
          $display("FAIL state cyc=%0d got count=%h tick=%b expired=%b pulse=%b exp count=%h tick=%b expired=%b pulse=%b",
                   e.cyc, bus.count_bcd, bus.tick, bus.expired, bus.expire_pulse,
                   exp_bcd, e.tick, exp_expired, e.ep);
        end
        if (e.tick) begin
          $display("tick cyc=%0d count=%h expired=%b pulse=%b",
                   e.cyc, bus.count_bcd, bus.expired, bus.expire_pulse);
        end
      end
    end
  end

  initial begin
    logic       r, s, l, u;
    logic [7:0] lb;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.load     = 1'b0;
    bus.load_bcd = '0;
    bus.count_up = 1'b0;
    #1;

    // Reset, then free run from 20 down.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    run(10, 1'b1, 1'b0);

    // Reach zero, then saturate without further pulses.
    load_val(8'h01, 1'b1, 1'b0);
    run(14, 1'b1, 1'b0);

    // Pause mid-period keeps the partial second.
    load_val(8'h45, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0);

    // Load coinciding with a wrap: load wins, nibble F clamps to 9.
    load_val(8'h30, 1'b1, 1'b0);
    run(3, 1'b1, 1'b0);
    load_val(8'h5F, 1'b1, 1'b0);
    run(6, 1'b1, 1'b0);

    // Up mode to all-9s, saturate, then switch direction.
    load_val(8'h98, 1'b1, 1'b1);
    run(9, 1'b1, 1'b1);
    run(5, 1'b1, 1'b0);

    // Load of terminal value: expired immediately, no pulse.
    load_val(8'h00, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);

    // Start dropped exactly on the wrap cycle, then resumed.
    load_val(8'h12, 1'b1, 1'b0);
    run(3, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(2, 1'b1, 1'b0);

    // Reset mid-run restores the initial value and prescaler.
    load_val(8'h07, 1'b1, 1'b0);
    run(3, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    run(6, 1'b1, 1'b0);

    // Randomised traffic.
    u = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       lb = 8'($urandom_range(0, 255));
        1:       lb = {4'h0, 4'($urandom_range(0, 3))};
        2:       lb = {4'h9, 4'($urandom_range(6, 15))};
        default: lb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      if ($urandom_range(0, 59) == 0) u = ~u;
      drive(r, s, l, lb, u);
    end

    #5;
    checks_total++;
    if (sb_q.size() == 0) begin
      checks_passed++;
    end else begin
      $display("FAIL drain got %0d pending entries exp 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
